// File: rtl/cobra_mover_if.sv
// rtl/cobra_mover_if.sv - control and head-position bundle between game logic and cobra_mover
interface cobra_mover_if #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 5
);
    logic              start;
    logic              pause;
    logic [1:0]        dir_in;
    logic [X_BITS-1:0] head_x;
    logic [Y_BITS-1:0] head_y;
    logic [1:0]        cur_dir;
    logic              step;
    logic              running;
    logic              game_over;

    modport master (
        output start, pause, dir_in,
        input  head_x, head_y, cur_dir, step, running, game_over
    );

    modport slave (
        input  start, pause, dir_in,
        output head_x, head_y, cur_dir, step, running, game_over
    );
endinterface

// File: rtl/cobra_mover.sv
// rtl/cobra_mover.sv - snake head mover with tick prescaler and IDLE/RUN/DEAD FSM
// Define COBRA_WRAP_EN to make the playfield border wrap instead of ending the game.
module cobra_mover #(
    parameter int         GRID_W    = 32,
    parameter int         GRID_H    = 24,
    parameter int         X_BITS    = 5,
    parameter int         Y_BITS    = 5,
    parameter int         STEP_DIV  = 25000000,
    parameter int         START_X   = 16,
    parameter int         START_Y   = 12,
    parameter logic [1:0] START_DIR = 2'b11
) (
    input  logic         clk,
    input  logic         reset,
    cobra_mover_if.slave bus
);

`ifdef COBRA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int P_BITS = $clog2(STEP_DIV);
    localparam logic [P_BITS-1:0] P_MAX   = P_BITS'(STEP_DIV - 1);
    localparam logic [X_BITS-1:0] X_MAX   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX   = Y_BITS'(GRID_H - 1);
    localparam logic [X_BITS-1:0] X_START = X_BITS'(START_X);
    localparam logic [Y_BITS-1:0] Y_START = Y_BITS'(START_Y);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [P_BITS-1:0] presc_q, presc_d;
    logic [X_BITS-1:0] head_x_q, head_x_d;
    logic [Y_BITS-1:0] head_y_q, head_y_d;
    logic [1:0]        cur_dir_q, cur_dir_d;
    logic              step_q, step_d;

    logic [1:0]        eff_dir;
    logic              border;
    logic              tick;
    logic              load;
    logic [X_BITS-1:0] move_x;
    logic [Y_BITS-1:0] move_y;

    // Tick edge and candidate move; the wrapped coordinate is only ever applied when WRAP is set.
    always_comb begin
        tick    = (state_q == S_RUN) && !bus.pause && (presc_q == P_MAX);
        load    = (state_q != S_RUN) && bus.start;
        eff_dir = (bus.dir_in == (cur_dir_q ^ 2'b01)) ? cur_dir_q : bus.dir_in;
        border  = 1'b0;
        move_x  = head_x_q;
        move_y  = head_y_q;
        case (eff_dir)
            DIR_UP: begin
                border = (head_y_q == '0);
                move_y = border ? Y_MAX : head_y_q - Y_BITS'(1);
            end
            DIR_DOWN: begin
                border = (head_y_q == Y_MAX);
                move_y = border ? '0 : head_y_q + Y_BITS'(1);
            end
            DIR_LEFT: begin
                border = (head_x_q == '0);
                move_x = border ? X_MAX : head_x_q - X_BITS'(1);
            end
            default: begin
                border = (head_x_q == X_MAX);
                move_x = border ? '0 : head_x_q + X_BITS'(1);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (tick && border && !WRAP) state_d = S_DEAD;
            S_DEAD:  if (bus.start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d   = presc_q;
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        cur_dir_d = cur_dir_q;
        step_d    = 1'b0;
        if (load) begin
            presc_d   = '0;
            head_x_d  = X_START;
            head_y_d  = Y_START;
            cur_dir_d = START_DIR;
        end else if (state_q == S_RUN && !bus.pause) begin
            if (tick) begin
                presc_d = '0;
                if (!border || WRAP) begin
                    head_x_d  = move_x;
                    head_y_d  = move_y;
                    cur_dir_d = eff_dir;
                    step_d    = 1'b1;
                end
            end else begin
                presc_d = presc_q + P_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            head_x_q  <= X_START;
            head_y_q  <= Y_START;
            cur_dir_q <= START_DIR;
            step_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            cur_dir_q <= cur_dir_d;
            step_q    <= step_d;
        end
    end

    assign bus.head_x    = head_x_q;
    assign bus.head_y    = head_y_q;
    assign bus.cur_dir   = cur_dir_q;
    assign bus.step      = step_q;
    assign bus.running   = (state_q == S_RUN);
    assign bus.game_over = (state_q == S_DEAD);

endmodule

// File: doc/cobra_mover.md
Name: cobra_mover

Overview:
- Consumer of the 2-bit direction code produced by the button-to-direction encoder: up=00, down=01, left=10, right=11.
- Owns the snake-head position on the playfield grid and advances it one cell per game tick.
- Rejects 180-degree reversals and detects border hits.
- Runs a small IDLE/RUN/DEAD state machine that the game logic and display path sit on top of.

Parameters:
- GRID_W, 32, playfield width in cells.
- GRID_H, 24, playfield height in cells.
- X_BITS, 5, width of head_x; must satisfy 2^X_BITS >= GRID_W.
- Y_BITS, 5, width of head_y; must satisfy 2^Y_BITS >= GRID_H.
- STEP_DIV, 25000000, clock cycles per game tick; must be >= 2.
- START_X, 16, head x after reset or restart.
- START_Y, 12, head y after reset or restart.
- START_DIR, 2'b11, direction after reset or restart.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; starts the game from IDLE, restarts it from DEAD.
- pause  input  1  level; while high, ticks are frozen.
- dir_in  input  2  requested direction from the encoder (up=00, down=01, left=10, right=11).
- head_x  output  X_BITS  current head column, 0 = left edge.
- head_y  output  Y_BITS  current head row, 0 = top edge.
- cur_dir  output  2  direction actually applied on the last move.
- step  output  1  one-cycle pulse, high in the cycle the new head value first appears.
- running  output  1  high in RUN.
- game_over  output  1  high in DEAD.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - state=IDLE, head_x=START_X, head_y=START_Y, cur_dir=START_DIR.
  - Prescaler=0; step, running and game_over all 0.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DEAD on a border hit (only when WRAP_EN is undefined).
  - DEAD -> RUN on start=1.
  - start is ignored while in RUN.
- Entering RUN from IDLE or DEAD reloads on that edge: head=(START_X,START_Y), cur_dir=START_DIR, prescaler=0.
- Prescaler:
  - Counts only in RUN with pause=0; counts 0..STEP_DIV-1.
  - The edge at which it holds STEP_DIV-1 is a tick edge; the prescaler wraps to 0 on that edge.
  - pause=1 freezes the prescaler value; counting resumes from the same value when pause drops.
  - start and pause high together in IDLE: go to RUN, prescaler stays frozen until pause=0.
- On a tick edge:
  - eff_dir = cur_dir if dir_in == (cur_dir ^ 2'b01), i.e. a reversal request; otherwise eff_dir = dir_in.
  - Move: up y-1, down y+1, left x-1, right x+1.
  - If the move stays inside the grid: head <= new value, cur_dir <= eff_dir, step <= 1.
- dir_in is sampled only on tick edges; changes between ticks have no effect.
- step is registered and is 0 in every cycle except the one following a successful move.
- Outputs hold their values in IDLE and DEAD.
- Arithmetic is unsigned. Border tests use the current coordinate before any update: x==0, x==GRID_W-1, y==0, y==GRID_H-1.

Optional Feature:
- Macro: COBRA_WRAP_EN.
- Defined: the border wraps around.
  - left at x=0 -> GRID_W-1; right at GRID_W-1 -> 0.
  - up at y=0 -> GRID_H-1; down at GRID_H-1 -> 0.
  - The wrapped move is a normal move: step=1, state stays RUN, DEAD is unreachable.
- Undefined: a move that would leave the grid goes to DEAD on the tick edge.
  - head and cur_dir stay unchanged, step stays 0, game_over=1 from the next cycle.

Test Plan:
- Bench configuration for all scenarios: GRID_W=8, GRID_H=8, STEP_DIV=4, START=(4,4), START_DIR=11.
- Basic run: reset, start pulse, dir_in=11, pause=0 -> step every 4 cycles; head (5,4),(6,4),(7,4); running=1.
- Reversal: moving right, set dir_in=10 -> next tick head x+1, cur_dir stays 11. Then dir_in=00 -> next tick y decrements by 1, cur_dir=00.
- Border, COBRA_WRAP_EN undefined: head (7,4) moving right, tick -> game_over=1, running=0, head stays (7,4), no step pulse. Then start -> head (4,4), cur_dir=11, running=1.
- Wrap, COBRA_WRAP_EN defined: (7,4) right -> (0,4) with step=1. From (3,0) with dir_in=00 -> (3,7).
- Pause: assert pause for 10 cycles mid-count -> no step, head constant. After release, the first step comes after the cycles remaining from the frozen prescaler value.
- Async reset: assert reset mid-RUN between clock edges -> outputs return to head=(4,4), cur_dir=11, running=0, game_over=0 immediately, without a clock edge; state=IDLE.
